// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit and the control FSM that drives it.
package inst_fetch_unit_pkg;

  // Global machine word size (instructions, addresses, PC, counters)
  localparam int WORD_SIZE_DEF  = 16;
  // Width of the saturating wait-cycle counter
  localparam int WAIT_CNT_W_DEF = 8;

  // Fetch unit states, 2-bit encodings
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } fetch_state_e;

  // Control FSM states that sequence the fetch unit (IF entry raises fetch_start)
  typedef enum logic [2:0] {
    CTRL_IF  = 3'd0,
    CTRL_ID  = 3'd1,
    CTRL_EX  = 3'd2,
    CTRL_MEM = 3'd3,
    CTRL_WB  = 3'd4
  } ctrl_state_e;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Bundle of control, memory and status signals between the fetch unit and its environment.
interface inst_fetch_unit_if
  import inst_fetch_unit_pkg::*;
#(
  parameter int WORD_SIZE  = WORD_SIZE_DEF,
  parameter int WAIT_CNT_W = WAIT_CNT_W_DEF
);

  logic                  fetch_start;
  logic                  flush;
  logic [WORD_SIZE-1:0]  pc_in;
  logic [WORD_SIZE-1:0]  data;
  logic                  inputReady;
  logic                  readM;
  logic [WORD_SIZE-1:0]  address;
  logic [WORD_SIZE-1:0]  inst;
  logic                  inst_valid;
  logic                  busy;
  logic [WORD_SIZE-1:0]  pc_plus1;
  logic [WORD_SIZE-1:0]  num_inst;
  logic [WAIT_CNT_W-1:0] wait_cycles;

  // Environment side: control FSM plus memory
  modport master (
    output fetch_start, flush, pc_in, data, inputReady,
    input  readM, address, inst, inst_valid, busy, pc_plus1, num_inst, wait_cycles
  );

  // Fetch unit side
  modport slave (
    input  fetch_start, flush, pc_in, data, inputReady,
    output readM, address, inst, inst_valid, busy, pc_plus1, num_inst, wait_cycles
  );

endinterface

// File: rtl/inst_fetch_unit_sat_counter.sv
// Saturating up-counter: load restarts the count at one, inc advances it until all ones.
module sat_counter
  import inst_fetch_unit_pkg::*;
#(
  parameter int WIDTH = WAIT_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: load wins over increment, increment stops at the maximum value
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = WIDTH'(1);
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: latches the PC, requests a memory read, waits for the
// read-complete strobe and loads the instruction register, with flush and statistics.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int WORD_SIZE  = WORD_SIZE_DEF,
  parameter int WAIT_CNT_W = WAIT_CNT_W_DEF
) (
  input logic              clk,
  input logic              reset,
  inst_fetch_unit_if.slave bus
);

  fetch_state_e          state_q;
  fetch_state_e          state_d;
  logic                  readM_q;
  logic                  instValid_q;
  logic [WORD_SIZE-1:0]  address_q;
  logic [WORD_SIZE-1:0]  pcPlus1_q;
  logic [WORD_SIZE-1:0]  inst_q;
  logic [WORD_SIZE-1:0]  numInst_q;
  logic [WAIT_CNT_W-1:0] waitCount;
  logic                  startAccept;
  logic                  readyAccept;
  logic                  waitInc;

  // Next-state decode; flush beats both a new request and a read completion
  always_comb begin
    state_d     = state_q;
    startAccept = 1'b0;
    readyAccept = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.fetch_start && !bus.flush) begin
          state_d     = REQ;
          startAccept = 1'b1;
        end
      end
      REQ: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else if (bus.inputReady) begin
          state_d     = DONE;
          readyAccept = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else if (bus.inputReady) begin
          state_d     = DONE;
          readyAccept = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Every further cycle spent with the read outstanding adds one to the wait count
  assign waitInc = (state_d == WAIT);

  // State and registered read request; readM follows the state being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      readM_q     <= 1'b0;
      instValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      readM_q     <= (state_d == REQ) || (state_d == WAIT);
      instValid_q <= readyAccept;
    end
  end

  // Datapath registers: PC latch on acceptance, IR and fetch count on completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address_q <= '0;
      pcPlus1_q <= WORD_SIZE'(1);
      inst_q    <= '0;
      numInst_q <= '0;
    end else begin
      if (startAccept) begin
        address_q <= bus.pc_in;
        pcPlus1_q <= bus.pc_in + 1'b1;
      end
      if (readyAccept) begin
        inst_q    <= bus.data;
        numInst_q <= numInst_q + 1'b1;
      end
    end
  end

  sat_counter #(
    .WIDTH (WAIT_CNT_W)
  ) u_waitCounter (
    .clk     (clk),
    .reset   (reset),
    .load_i  (startAccept),
    .inc_i   (waitInc),
    .count_o (waitCount)
  );

  assign bus.readM       = readM_q;
  assign bus.address     = address_q;
  assign bus.inst        = inst_q;
  assign bus.inst_valid  = instValid_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.pc_plus1    = pcPlus1_q;
  assign bus.num_inst    = numInst_q;
  assign bus.wait_cycles = waitCount;

endmodule
